// File: rtl/sel_demux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sel_demux_pkg : shared constants, slot state and select check for    |
// |                 the six-way registered demultiplexer                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sel_demux_pkg;

    localparam int NCH   = 6;
    localparam int SEL_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
        return sel < SEL_W'(NCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_slot : one-entry holding slot with valid/ready drain, pass-    |
// |              through refill and a wrapping accept counter            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module demux_slot
    import sel_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             valid,
    input  logic             ready,
    output logic             can_load,
    output logic [CNT_W-1:0] count
);

    slot_state_t      r_state;
    logic [W-1:0]     r_data;
    logic [CNT_W-1:0] r_count;

    // A full slot being drained this cycle may be refilled in the same cycle
    assign can_load = (r_state == EMPTY) || ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_count <= '0;
        end else if (load) begin
            r_state <= FULL;
            r_data  <= din;
            r_count <= r_count + CNT_W'(1);
        end else if (r_state == FULL && ready) begin
            r_state <= EMPTY;
        end
    end

    assign dout  = r_data;
    assign valid = (r_state == FULL);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sel_demux6.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sel_demux6 : six-way registered demultiplexer with per-channel slots, |
// |              drop counter for illegal selects                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sel_demux6
    import sel_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [W-1:0]         in_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*W-1:0]     out_data,
    output logic [CNT_W-1:0]     drop_count,
    output logic [NCH*CNT_W-1:0] accept_count
);

    localparam int          NSEL     = 2 ** SEL_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [NCH-1:0]   w_can_load;
    logic [NSEL-1:0]  w_ready_by_sel;
    logic             w_legal;
    logic             w_fire;
    logic [CNT_W-1:0] r_drop_count;

    assign w_legal = sel_legal(in_sel);
    assign w_fire  = in_valid && in_ready;

    // Illegal selects are always accepted so they can be discarded
    assign w_ready_by_sel = {{(NSEL-NCH){1'b1}}, w_can_load};
    assign in_ready       = w_ready_by_sel[in_sel];

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            demux_slot #(
                .W (W)
            ) u_slot (
                .clk      (clk),
                .resetn   (resetn),
                .load     (w_fire && w_legal && (in_sel == SEL_W'(g))),
                .din      (in_data),
                .dout     (out_data[g*W +: W]),
                .valid    (out_valid[g]),
                .ready    (out_ready[g]),
                .can_load (w_can_load[g]),
                .count    (accept_count[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_drop_count <= '0;
        end else if (w_fire && !w_legal && r_drop_count != C_CNT_MAX) begin
            r_drop_count <= r_drop_count + CNT_W'(1);
        end
    end

    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: doc/sel_demux6.md
# sel_demux6

Six-way registered demultiplexer: the distribution side of the 3-bit-select, six-source 4-bit selector. Accepts one tagged word per cycle on a valid/ready input and steers it into one of six output channels, each with its own one-entry holding slot and independent valid/ready handshake. Sits upstream of per-channel consumers, so one producer can feed six sinks without stalling on idle ones. Words with an out-of-range select are consumed, dropped and counted.

## Interface
- W, 4, data width per word
- NCH, 6, number of output channels (fixed at 6; sel values 6 and 7 are illegal)
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous reset, active-low; single clock domain
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted this cycle when in_valid and in_ready are both 1
- in_sel  in  3  destination channel, 0..5 legal
- in_data  in  W  payload
- out_valid  out  NCH  bit i: channel i slot holds a word
- out_ready  in  NCH  bit i: consumer i takes the word this cycle
- out_data  out  NCH*W  channel i payload at bits [i*W +: W]
- drop_count  out  8  saturating count of words accepted with in_sel of 6 or 7
- accept_count  out  NCH*8  per-channel wrapping count of words delivered into slot i, at bits [i*8 +: 8]

## Operation
- Each channel slot is either EMPTY or FULL. out_valid[i] equals FULL.
- Slot i can load when it is EMPTY, or when it is FULL and out_ready[i] is 1 in the same cycle (pass-through refill).
- in_ready logic:
  - Legal in_sel = s: in_ready is 1 when slot s can load. This is a combinational path from out_ready[s].
  - Illegal in_sel (6 or 7): in_ready is 1.
  - When in_valid is 0, in_ready still reflects in_sel.
- Legal accept (in_valid, in_ready, sel = s):
  - Slot s loads in_data and is FULL next cycle.
  - accept_count[s] increments and wraps 255 to 0.
- Illegal accept: nothing is loaded. drop_count increments and saturates at 255.
- Slot drain: if FULL, out_ready[i] is 1 and slot i does not load, slot i goes EMPTY next cycle.
- out_data[i] holds its last value while EMPTY. Consumers must qualify it with out_valid.
- out_ready on an EMPTY slot has no effect.
- Per-channel ordering is preserved. With one slot per channel, no reordering is possible.

## Timing
- Reset (resetn = 0 sampled at a clk edge):
  - All slots EMPTY, so out_valid = 0.
  - out_data = 0, drop_count = 0, accept_count = 0.
  - Reset overrides any handshake in the same cycle. A word held in a slot is discarded.
  - in_ready is combinational and valid during reset. Any handshake completed during reset is ignored.
- Latency: a word accepted at edge k appears on out_valid/out_data after edge k. The consumer can take it at edge k+1.
- Throughput:
  - One word per cycle into a single channel when its consumer holds out_ready = 1.
  - Sustained alternation across channels, one per cycle.
- Simultaneous drain and load on the same slot: the new word replaces the old one, the slot stays FULL and the count increments.
- Back-pressure: a FULL slot with out_ready = 0 blocks only inputs targeting that channel. Other channels are unaffected.
- Saturation: drop_count holds at 255. accept_count wraps.

## Structure
- Package sel_demux_pkg holds:
  - NCH = 6, SEL_W = 3, CNT_W = 8
  - a function sel_legal(sel) returning sel < NCH
  - typedef slot_state_t {EMPTY, FULL}
- Sub-module demux_slot: one-entry register slice with the load/drain rules above, its own accept counter and ports clk, resetn, load, din, dout, valid, ready, can_load. Instantiated NCH times by a generate loop. The top level keeps only in_sel decode, in_ready muxing and drop_count.

## Test plan
- Reset then idle: after resetn goes 0 then 1, out_valid = 6'b0, drop_count = 0, and with in_sel = 2 in_ready = 1.
- Single route: in_sel = 3, in_data = 4'hA, out_ready = 0. Then out_valid = 6'b001000 and out_data[15:12] = A on the next cycle. A second word to channel 3 sees in_ready = 0. Raising out_ready[3] drains it and accept_count[3] = 1.
- Pass-through: channel 0 is FULL with 4'h1, out_ready[0] = 1, and 4'h2 is sent to sel 0 in the same cycle. Then in_ready = 1, the slot stays FULL with 4'h2 and the consumer sees 1 then 2.
- Illegal select: send 300 words with in_sel = 7. in_ready = 1 throughout, out_valid never changes and drop_count saturates at 255.
- Independence and reset: channel 5 is stalled FULL. Words to sel 0..4 each land one cycle after acceptance. resetn is pulsed low while slots are FULL, and all out_valid and counters are 0 the next cycle.
